// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I control unit.
// Holds the state encodings, ALU operation codes, opcodes, datapath mux select codes,
// the internal control-word struct and the branch condition helper.
package multicycle_controller_pkg;

  localparam int unsigned STATE_W   = 4;
  localparam int unsigned ALUCTRL_W = 3;
  localparam int unsigned OP_W      = 7;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned SEL_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALUCTRL_W-1:0] ALU_SLL = 3'b101;
  localparam logic [ALUCTRL_W-1:0] ALU_SRL = 3'b110;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

  localparam logic             ADR_PC        = 1'b0;
  localparam logic             ADR_ALUOUT    = 1'b1;
  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;
  localparam logic [SEL_W-1:0] SRCA_PC       = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1      = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_RS2      = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM      = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR     = 2'b10;
  localparam logic [SEL_W-1:0] IMM_I         = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S         = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B         = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J         = 2'b11;

  // State-decoded control word; branch marks the flag-qualified PC write.
  typedef struct packed {
    logic             pc_write;
    logic             branch;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic [SEL_W-1:0] result_src;
    logic [SEL_W-1:0] alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    aluop_e           alu_op;
  } ctrl_t;

  // Branch condition from funct3 and the ALU flags of the rs1-rs2 subtraction.
  function automatic logic branch_taken(input logic [FUNCT3_W-1:0] funct3,
                                        input logic zero, input logic n, input logic v);
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = n ^ v;
      3'b101:  branch_taken = ~(n ^ v);
      default: branch_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in, control out.
// master: the controller; slave: the datapath (or a bench acting as one).
interface multicycle_controller_if;
  import multicycle_controller_pkg::*;

  logic [OP_W-1:0]      op;
  logic [FUNCT3_W-1:0]  funct3;
  logic                 funct7b5;
  logic                 Zero;
  logic                 N;
  logic                 V;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegWrite;
  logic [SEL_W-1:0]     ResultSrc;
  logic [SEL_W-1:0]     ALUSrcA;
  logic [SEL_W-1:0]     ALUSrcB;
  logic [SEL_W-1:0]     ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic [STATE_W-1:0]   StateOut;

  modport master (
    input  op, funct3, funct7b5, Zero, N, V,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, StateOut
  );

  modport slave (
    output op, funct3, funct7b5, Zero, N, V,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, StateOut
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps ALUOp, funct3, funct7b5 and op[5] to the 3-bit ALU operation code.
// Ports: alu_op_i, funct3_i, funct7b5_i, op5_i in; alu_control_c_o out (combinational).
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  aluop_e                alu_op_i,
  input  logic [FUNCT3_W-1:0]   funct3_i,
  input  logic                  funct7b5_i,
  input  logic                  op5_i,
  output logic [ALUCTRL_W-1:0]  alu_control_c_o
);

  always_comb begin
    alu_control_c_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_c_o = ALU_ADD;
      ALUOP_SUB: alu_control_c_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // op[5] separates R-type from addi, whose bit 30 is immediate data.
          3'b000:  alu_control_c_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_c_o = ALU_SLL;
          3'b010:  alu_control_c_o = ALU_SLT;
          3'b011:  alu_control_c_o = ALU_SLT;
          3'b100:  alu_control_c_o = ALU_XOR;
          3'b101:  alu_control_c_o = ALU_SRL;
          3'b110:  alu_control_c_o = ALU_OR;
          default: alu_control_c_o = ALU_AND;
        endcase
      end
      default: alu_control_c_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing RV32I instructions through the multicycle datapath.
// Ports: clk, reset (sync, active-high); bus (master modport) carrying op/funct3/funct7b5 and
// ALU flags in, mux selects, write enables, ALUControl and StateOut out.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_e state_q;
  state_e state_d;
  state_e dec_state;
  ctrl_t  ctrl;
  logic   taken;
  logic [ALUCTRL_W-1:0] alu_control;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and control decode; under reset the outputs decode as FETCH.
  always_comb begin
    ctrl      = '0;
    state_d   = S_FETCH;
    dec_state = reset ? S_FETCH : state_q;
    case (dec_state)
      S_FETCH: begin
        ctrl.adr_src    = ADR_PC;
        ctrl.ir_write   = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.pc_write   = 1'b1;
        state_d         = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        state_d        = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = ADR_ALUOUT;
        state_d         = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.adr_src    = ADR_ALUOUT;
        ctrl.mem_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_EXECUTER: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_EXECUTEI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_ALUWB;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
        state_d         = S_ALUWB;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.branch     = 1'b1;
        state_d         = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Flags are used combinationally in the BRANCH cycle only.
  assign taken = branch_taken(bus.funct3, bus.Zero, bus.N, bus.V);

  alu_decoder u_alu_decoder (
    .alu_op_i        (ctrl.alu_op),
    .funct3_i        (bus.funct3),
    .funct7b5_i      (bus.funct7b5),
    .op5_i           (bus.op[5]),
    .alu_control_c_o (alu_control)
  );

  // Immediate format follows the opcode alone.
  always_comb begin
    bus.ImmSrc = IMM_I;
    case (bus.op)
      OP_STORE:  bus.ImmSrc = IMM_S;
      OP_BRANCH: bus.ImmSrc = IMM_B;
      OP_JAL:    bus.ImmSrc = IMM_J;
      default:   bus.ImmSrc = IMM_I;
    endcase
  end

  // Architectural writes are suppressed for the whole reset cycle.
  assign bus.PCWrite    = ~reset & (ctrl.pc_write | (ctrl.branch & taken));
  assign bus.IRWrite    = ~reset & ctrl.ir_write;
  assign bus.RegWrite   = ~reset & ctrl.reg_write;
  assign bus.MemWrite   = ~reset & ctrl.mem_write;
  assign bus.AdrSrc     = ctrl.adr_src;
  assign bus.ResultSrc  = ctrl.result_src;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.StateOut   = state_q;

endmodule
